pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised successor to the pipeline's fixed-width mid-stage register. Carries one WIDTH-bit instruction/control bundle between two pipeline stages with a valid/ready handshake, an optional one-entry skid buffer that breaks the combinational ready path, distinct hold (En low) and flush (bubble insert) controls, and saturating stall/flush event counters for performance debug. Sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- WIDTH, 298: payload width in bits.
- SKID, 1: 0 = single register, with combinational dn_ready→up_ready path; 1 = main register plus skid entry, with registered up_ready.
- CNT_W, 16: width of each event counter.

- Clk  in  1  clock; all state updates on the falling edge of Clk.
- Rst  in  1  synchronous, active-high reset.
- En  in  1  global stage enable; low freezes all state.
- Flush  in  1  discard the stage contents and insert a bubble.
- up_valid  in  1  upstream bundle valid.
- up_ready  out  1  stage can accept a bundle.
- up_data  in  WIDTH  upstream bundle.
- dn_valid  out  1  downstream bundle valid.
- dn_ready  in  1  downstream accepts.
- dn_data  out  WIDTH  downstream bundle.
- stall_cnt  out  CNT_W  cycles with dn_valid high and dn_ready low.
- flush_cnt  out  CNT_W  number of accepted Flush cycles that discarded at least one valid entry.

## Operation
- State: main entry M {valid, data}. When SKID=1, there is also a skid entry S {valid, data}. Occupancy states: EMPTY (M.v=0), ONE (M.v=1, S.v=0), FULL (M.v=1, S.v=1; only reachable when SKID=1).
- dn_valid = En & M.v; dn_data = M.data, which is all zeros when M is invalid.
- up_ready:
  - SKID=1: En & !S.v.
  - SKID=0: En & (!M.v | dn_ready).
- Accept = up_valid & up_ready. Drain = dn_valid & dn_ready.
- Transitions apply when En=1, Flush=0. Unlisted combinations hold state.
  - EMPTY + accept → ONE; M ← up_data.
  - ONE + accept + drain → ONE; M ← up_data.
  - ONE + drain only → EMPTY.
  - ONE + accept only → FULL (SKID=1), with S ← up_data. With SKID=0, this case cannot occur because up_ready is 0.
  - FULL + drain → ONE; M ← S and S cleared. No accept is possible because up_ready is 0.
- Flush=1 with En=1: M and S cleared (valid 0, data zero) → EMPTY. An accept in the same cycle is dropped. A drain in the same cycle completes: downstream has sampled the current M.
- En=0: no transfers, state and counters frozen, up_ready=0 and dn_valid=0. Flush is ignored while En=0.
- Priority: Rst > En=0 > Flush > handshake.
- Counters:
  - stall_cnt increments each enabled cycle with M.v & !dn_ready & !Flush.
  - flush_cnt increments on a flush cycle when M.v | S.v.
  - Both saturate at all ones and never wrap.

## Timing
- Rst on a falling edge: M, S, and both counters cleared → EMPTY. Outputs after reset: dn_valid=0, dn_data=0, stall_cnt=0, flush_cnt=0; up_ready=En.
- Latency: a bundle accepted at edge n is on dn_data with dn_valid=1 immediately after edge n. Throughput is 1 bundle per cycle at steady state.
- SKID=1: up_ready is a function of registered state and En only. There is no path from dn_ready to up_ready.
- SKID=0: there is a combinational path from dn_ready to up_ready.
- Order is preserved: S always drains after M, with no reordering or duplication.
- Rst mid-transfer discards all entries; the counters do not count the discard as a flush.

## Structure
- Shared package pipe_pkg:
  - occupancy enum {EMPTY, ONE, FULL};
  - PIPE_BUNDLE_W default constant (298);
  - counter width default.
- Sub-module pipe_sat_cnt (params W; ports Clk, Rst, En, inc, count): a saturating counter, instantiated twice.
- The SKID=0 build removes S via a generate block; the same ports apply in both modes.

## Test plan
- Reset/idle: hold Rst 2 cycles, then release with En=1, up_valid=0 → dn_valid=0, dn_data=0, up_ready=1, both counters 0.
- Streaming: SKID=1, dn_ready=1, push 0x1..0x8 on consecutive cycles → dn_data 0x1..0x8 one cycle later each, no gaps, stall_cnt=0.
- Backpressure/skid: SKID=1, push 0xA then 0xB with dn_ready=0 → FULL and up_ready=0. Raise dn_ready → 0xA then 0xB emerge in order, with stall_cnt equal to the number of cycles dn_ready was low.
- Flush collision: FULL state with Flush=1 and up_valid=1 (data 0xC) in the same cycle → EMPTY, 0xC dropped, dn_data=0, flush_cnt incremented by 1. A flush while EMPTY leaves flush_cnt unchanged.
- Hold: En=0 for 3 cycles while in state ONE with dn_ready=1 → dn_valid=0, up_ready=0, M unchanged, counters frozen. Re-enable → original data delivered.
- Saturation/SKID=0: CNT_W=4, dn_ready=0 for 20 cycles → stall_cnt=15 and holds. With SKID=0, toggling dn_ready toggles up_ready in the same cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared occupancy type, default widths and occupancy decode for pipeline stage buffers
package pipe_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;
    localparam int PIPE_BUNDLE_W = 298;
    localparam int PIPE_CNT_W = 16;
    function automatic occ_e occ_of(input logic mv, input logic sv);
        return mv ? (sv ? FULL : ONE) : EMPTY;
    endfunction
endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: falling-edge event counter that sticks at all ones
module pipe_sat_cnt #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         En,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;
    always_comb count_d = (En & inc & ~&count_q) ? count_q + W'(1) : count_q;
    always_ff @(negedge Clk) count_q <= Rst ? '0 : count_d;
    assign count = count_q;
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline register with optional skid entry, flush and stall/flush counters
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_BUNDLE_W,
    parameter bit SKID  = 1'b1,
    parameter int CNT_W = PIPE_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    logic m_v_q, m_v_d, s_v_q, s_v_d, accept, drain;
    logic [WIDTH-1:0] m_d_q, m_d_d, s_d_q, s_d_d;
    occ_e occ;
    always_comb begin
        occ = occ_of(m_v_q, s_v_q);
        up_ready = SKID ? En & (occ != FULL) : En & ((occ == EMPTY) | dn_ready);
        dn_valid = En & m_v_q;
        dn_data = m_d_q;
        accept = up_valid & up_ready;
        drain = dn_valid & dn_ready;
        m_v_d = m_v_q;
        m_d_d = m_d_q;
        s_v_d = s_v_q;
        s_d_d = s_d_q;
        if (En & Flush) begin
            m_v_d = 1'b0;
            m_d_d = '0;
            s_v_d = 1'b0;
            s_d_d = '0;
        end else if (drain) begin
            // skid entry moves up first; a new bundle only lands when S was empty
            m_v_d = s_v_q | accept;
            m_d_d = s_v_q ? s_d_q : accept ? up_data : '0;
            s_v_d = 1'b0;
            s_d_d = '0;
        end else if (accept) begin
            if (occ == EMPTY) begin
                m_v_d = 1'b1;
                m_d_d = up_data;
            end else begin
                s_v_d = 1'b1;
                s_d_d = up_data;
            end
        end
    end
    always_ff @(negedge Clk) begin
        if (Rst) begin
            m_v_q <= 1'b0;
            m_d_q <= '0;
        end else begin
            m_v_q <= m_v_d;
            m_d_q <= m_d_d;
        end
    end
    if (SKID) begin : g_skid
        always_ff @(negedge Clk) begin
            if (Rst) begin
                s_v_q <= 1'b0;
                s_d_q <= '0;
            end else begin
                s_v_q <= s_v_d;
                s_d_q <= s_d_d;
            end
        end
    end else begin : g_noskid
        assign s_v_q = 1'b0;
        assign s_d_q = '0;
    end
    pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .En    (En),
        .inc   (m_v_q & ~dn_ready & ~Flush),
        .count (stall_cnt)
    );
    pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .En    (En),
        .inc   (Flush & (m_v_q | s_v_q)),
        .count (flush_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of the skid build and a SKID=0, 4-bit-counter build
module tb_pipe_stage_buf;
    import pipe_pkg::*;
    logic Clk = 1'b1;
    logic Rst;
    logic en, fl, uv, dr, ur, dv;
    logic [PIPE_BUNDLE_W-1:0] ud, dd;
    logic [15:0] sc, fc;
    logic en0, uv0, dr0, ur0, dv0;
    logic [7:0] ud0, dd0;
    logic [3:0] sc0, fc0;
    int vectors = 0;
    int errors = 0;
    always #5 Clk = ~Clk;
    pipe_stage_buf u_dut (
        .Clk(Clk), .Rst(Rst), .En(en), .Flush(fl),
        .up_valid(uv), .up_ready(ur), .up_data(ud),
        .dn_valid(dv), .dn_ready(dr), .dn_data(dd),
        .stall_cnt(sc), .flush_cnt(fc)
    );
    pipe_stage_buf #(.WIDTH(8), .SKID(1'b0), .CNT_W(4)) u_dut0 (
        .Clk(Clk), .Rst(Rst), .En(en0), .Flush(1'b0),
        .up_valid(uv0), .up_ready(ur0), .up_data(ud0),
        .dn_valid(dv0), .dn_ready(dr0), .dn_data(dd0),
        .stall_cnt(sc0), .flush_cnt(fc0)
    );
    task automatic tick();
        @(negedge Clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [PIPE_BUNDLE_W-1:0] obs, input logic [PIPE_BUNDLE_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        Rst = 1'b1; en = 1'b1; fl = 1'b0; uv = 1'b0; dr = 1'b0; ud = '0;
        en0 = 1'b1; uv0 = 1'b0; dr0 = 1'b0; ud0 = '0;
        tick();
        tick();
        Rst = 1'b0;
        tick();
        chk("rst_dv", dv, 0);
        chk("rst_dd", dd, 0);
        chk("rst_ur", ur, 1);
        chk("rst_sc", sc, 0);
        chk("rst_fc", fc, 0);
        chk("rst0_dv", dv0, 0);
        chk("rst0_ur", ur0, 1);
        dr = 1'b1;
        uv = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            ud = PIPE_BUNDLE_W'(i);
            tick();
            chk("stream_dv", dv, 1);
            chk("stream_dd", dd, PIPE_BUNDLE_W'(i));
            chk("stream_ur", ur, 1);
        end
        uv = 1'b0;
        tick();
        chk("stream_end_dv", dv, 0);
        chk("stream_end_dd", dd, 0);
        chk("stream_sc", sc, 0);
        dr = 1'b0; uv = 1'b1; ud = 'hA;
        tick();
        chk("bp_a_dd", dd, 'hA);
        chk("bp_a_sc", sc, 0);
        ud = 'hB;
        tick();
        chk("bp_full_ur", ur, 0);
        chk("bp_b_sc", sc, 1);
        uv = 1'b0;
        tick();
        chk("bp_hold_dd", dd, 'hA);
        chk("bp_hold_sc", sc, 2);
        dr = 1'b1;
        #1;
        chk("bp_no_comb_ur", ur, 0);
        tick();
        chk("bp_b_out", dd, 'hB);
        chk("bp_b_dv", dv, 1);
        chk("bp_ur_back", ur, 1);
        tick();
        chk("bp_drained", dv, 0);
        chk("bp_final_sc", sc, 2);
        dr = 1'b0; uv = 1'b1; ud = 'hD;
        tick();
        ud = 'hE;
        tick();
        chk("fl_full_ur", ur, 0);
        chk("fl_pre_sc", sc, 3);
        fl = 1'b1; ud = 'hC;
        tick();
        chk("fl_dv", dv, 0);
        chk("fl_dd", dd, 0);
        chk("fl_cnt", fc, 1);
        chk("fl_sc", sc, 3);
        tick();
        chk("fl_empty_dv", dv, 0);
        chk("fl_empty_cnt", fc, 1);
        fl = 1'b0; ud = 'h55;
        tick();
        chk("hold_load", dd, 'h55);
        uv = 1'b0; dr = 1'b1; en = 1'b0;
        #1;
        chk("hold_dv", dv, 0);
        chk("hold_ur", ur, 0);
        tick();
        fl = 1'b1;
        tick();
        fl = 1'b0;
        tick();
        chk("hold_sc", sc, 3);
        chk("hold_fc", fc, 1);
        en = 1'b1;
        #1;
        chk("hold_re_dv", dv, 1);
        chk("hold_re_dd", dd, 'h55);
        tick();
        chk("hold_drained", dv, 0);
        uv0 = 1'b1; ud0 = 8'h5A;
        tick();
        chk("s0_dd", dd0, 'h5A);
        chk("s0_ur_lo", ur0, 0);
        uv0 = 1'b0; dr0 = 1'b1;
        #1;
        chk("s0_ur_hi", ur0, 1);
        dr0 = 1'b0;
        #1;
        chk("s0_ur_lo2", ur0, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_sc", sc0, 15);
        tick();
        chk("sat_hold", sc0, 15);
        chk("sat_dd", dd0, 'h5A);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
